// File: rtl/pid_seq_pkg.sv
// Shared constants for the PID per-sample sequencer: FSM state encodings,
// default PID register addresses and a counter-width helper.
package pid_seq_pkg;

  localparam int unsigned STATE_W    = 3;
  localparam int unsigned PID_ADDR_W = 4;
  localparam int unsigned OVR_W      = 16;

  localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] ST_ADC_REQ = 3'd1;
  localparam logic [STATE_W-1:0] ST_WR_FB   = 3'd2;
  localparam logic [STATE_W-1:0] ST_STEP    = 3'd3;
  localparam logic [STATE_W-1:0] ST_SETTLE  = 3'd4;
  localparam logic [STATE_W-1:0] ST_RD_CTRL = 3'd5;
  localparam logic [STATE_W-1:0] ST_RD_CAP  = 3'd6;
  localparam logic [STATE_W-1:0] ST_DAC_OUT = 3'd7;

  localparam logic [PID_ADDR_W-1:0] FB_ADDR_DEF   = 4'd4;
  localparam logic [PID_ADDR_W-1:0] CTRL_ADDR_DEF = 4'd12;

  // Bits needed to hold max_val (at least one).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 32'd2) ? 32'd1 : 32'($clog2(max_val + 32'd1));
  endfunction

endpackage

// File: rtl/pid_seq_timer.sv
// Loadable down-counter with a zero flag. Stops at zero; a load wins over
// counting. Shared between the settle delay and the ADC timeout.
module pid_seq_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_zero_c
);

  logic [CNT_W-1:0] r_cnt;

  // Load or count down towards zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/pid_sample_sequencer.sv
// Per-sample sequencer for the PID peripheral: on a sample tick fetch an ADC
// word, write it to the PID feedback register, pulse the step enable, read the
// control action back and present it to the DAC.
// Optional build macro PID_SEQ_TIMEOUT_EN: bounds the wait for adc_ack to
// ADC_TIMEOUT cycles and reports a sticky timeout flag.
module pid_sample_sequencer
  import pid_seq_pkg::*;
#(
  parameter int unsigned            DATA_W        = 32,
  parameter logic [PID_ADDR_W-1:0]  FB_ADDR       = FB_ADDR_DEF,
  parameter logic [PID_ADDR_W-1:0]  CTRL_ADDR     = CTRL_ADDR_DEF,
  parameter int unsigned            SETTLE_CYCLES = 2,
  parameter int unsigned            ADC_TIMEOUT   = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_enable,
  input  logic                  i_tick,
  output logic                  o_adc_req,
  input  logic                  i_adc_ack,
  input  logic [DATA_W-1:0]     i_adc_data,
  output logic                  o_pid_cs,
  output logic                  o_pid_write,
  output logic                  o_pid_read,
  output logic [PID_ADDR_W-1:0] o_pid_addr,
  output logic [DATA_W-1:0]     o_pid_wdata,
  input  logic [DATA_W-1:0]     i_pid_rdata,
  output logic                  o_pid_en,
  output logic                  o_dac_valid,
  input  logic                  i_dac_ready,
  output logic [DATA_W-1:0]     o_dac_data,
  output logic                  o_busy,
  output logic [OVR_W-1:0]      o_overrun_cnt,
  output logic                  o_timeout
);

`ifdef PID_SEQ_TIMEOUT_EN
  localparam int unsigned TMR_MAX = (ADC_TIMEOUT > SETTLE_CYCLES) ? ADC_TIMEOUT : SETTLE_CYCLES;
`else
  localparam int unsigned TMR_MAX = SETTLE_CYCLES;
`endif
  localparam int unsigned TMR_W = cnt_width(TMR_MAX);
  // Timer runs load..0 inclusive, so load N-1 to spend N cycles in a state.
  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 32'd1);
`ifdef PID_SEQ_TIMEOUT_EN
  localparam logic [TMR_W-1:0] ADC_LOAD    = TMR_W'(ADC_TIMEOUT - 32'd1);
`endif
  localparam logic [OVR_W-1:0] OVR_MAX     = '1;

  // Reject configurations that would make the settle/timeout windows empty.
  if (SETTLE_CYCLES < 1 || ADC_TIMEOUT < 1) begin : g_bad_cfg
    $error("pid_sample_sequencer: SETTLE_CYCLES and ADC_TIMEOUT must be >= 1");
  end

  logic [STATE_W-1:0]    r_state;
  logic                  r_adc_req;
  logic                  r_pid_cs;
  logic                  r_pid_write;
  logic                  r_pid_read;
  logic [PID_ADDR_W-1:0] r_pid_addr;
  logic [DATA_W-1:0]     r_pid_wdata;
  logic                  r_pid_en;
  logic                  r_dac_valid;
  logic [DATA_W-1:0]     r_dac_data;
  logic                  r_busy;
  logic [OVR_W-1:0]      r_ovr;

  logic [STATE_W-1:0]    w_state_nxt;
  logic [DATA_W-1:0]     w_wdata_nxt;
  logic [DATA_W-1:0]     w_dac_data_nxt;
  logic                  w_tmr_load;
  logic [TMR_W-1:0]      w_tmr_val;
  logic                  w_tmr_zero;
`ifdef PID_SEQ_TIMEOUT_EN
  logic                  w_timeout_set;
  logic                  r_timeout;
`endif

  pid_seq_timer #(
    .CNT_W      (TMR_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_zero_c   (w_tmr_zero)
  );

  // Next-state, timer control and captured data.
  always_comb begin
    w_state_nxt    = r_state;
    w_wdata_nxt    = '0;
    w_dac_data_nxt = r_dac_data;
    w_tmr_load     = 1'b0;
    w_tmr_val      = SETTLE_LOAD;
`ifdef PID_SEQ_TIMEOUT_EN
    w_timeout_set  = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (i_tick && i_enable) begin
          w_state_nxt = ST_ADC_REQ;
`ifdef PID_SEQ_TIMEOUT_EN
          w_tmr_load  = 1'b1;
          w_tmr_val   = ADC_LOAD;
`endif
        end
      end
      ST_ADC_REQ: begin
        if (i_adc_ack) begin
          w_state_nxt = ST_WR_FB;
          w_wdata_nxt = i_adc_data;
        end
`ifdef PID_SEQ_TIMEOUT_EN
        else if (w_tmr_zero) begin
          w_state_nxt   = ST_IDLE;
          w_timeout_set = 1'b1;
        end
`endif
      end
      ST_WR_FB:   w_state_nxt = ST_STEP;
      ST_STEP: begin
        w_state_nxt = ST_SETTLE;
        w_tmr_load  = 1'b1;
        w_tmr_val   = SETTLE_LOAD;
      end
      ST_SETTLE: begin
        if (w_tmr_zero) w_state_nxt = ST_RD_CTRL;
      end
      ST_RD_CTRL: w_state_nxt = ST_RD_CAP;
      ST_RD_CAP: begin
        w_state_nxt    = ST_DAC_OUT;
        w_dac_data_nxt = i_pid_rdata;
      end
      ST_DAC_OUT: begin
        if (i_dac_ready) w_state_nxt = ST_IDLE;
      end
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // State register plus outputs decoded from the next state, so every output is a flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_adc_req   <= 1'b0;
      r_pid_cs    <= 1'b0;
      r_pid_write <= 1'b0;
      r_pid_read  <= 1'b0;
      r_pid_addr  <= '0;
      r_pid_wdata <= '0;
      r_pid_en    <= 1'b0;
      r_dac_valid <= 1'b0;
      r_dac_data  <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_adc_req   <= (w_state_nxt == ST_ADC_REQ);
      r_pid_cs    <= (w_state_nxt == ST_WR_FB) || (w_state_nxt == ST_RD_CTRL);
      r_pid_write <= (w_state_nxt == ST_WR_FB);
      r_pid_read  <= (w_state_nxt == ST_RD_CTRL);
      r_pid_addr  <= (w_state_nxt == ST_WR_FB)   ? FB_ADDR   :
                     (w_state_nxt == ST_RD_CTRL) ? CTRL_ADDR : '0;
      r_pid_wdata <= w_wdata_nxt;
      r_pid_en    <= (w_state_nxt == ST_STEP);
      r_dac_valid <= (w_state_nxt == ST_DAC_OUT);
      r_dac_data  <= w_dac_data_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE);
    end
  end

  // Count ticks that arrive while a sequence is in flight, saturating.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovr <= '0;
    end else if (i_tick && (r_state != ST_IDLE) && (r_ovr != OVR_MAX)) begin
      r_ovr <= r_ovr + OVR_W'(1);
    end
  end

`ifdef PID_SEQ_TIMEOUT_EN
  // Sticky ADC timeout flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_timeout <= 1'b0;
    end else if (w_timeout_set) begin
      r_timeout <= 1'b1;
    end
  end

  assign o_timeout = r_timeout;
`else
  assign o_timeout = 1'b0;
`endif

  assign o_adc_req     = r_adc_req;
  assign o_pid_cs      = r_pid_cs;
  assign o_pid_write   = r_pid_write;
  assign o_pid_read    = r_pid_read;
  assign o_pid_addr    = r_pid_addr;
  assign o_pid_wdata   = r_pid_wdata;
  assign o_pid_en      = r_pid_en;
  assign o_dac_valid   = r_dac_valid;
  assign o_dac_data    = r_dac_data;
  assign o_busy        = r_busy;
  assign o_overrun_cnt = r_ovr;

endmodule
